// File: rtl/cherry_defines.sv
// cherry_defines: shared thread constants, register ids and the math instruction format
package cherry_defines;
  localparam int THREAD_W = 2;
  localparam int NUM_THREADS = 2 ** THREAD_W;
  localparam logic [3:0] REG_MATMUL_INPUT = 4'd1;
  localparam logic [3:0] REG_MATMUL_OUTPUT = 4'd2;
  typedef struct packed {
    logic valid;
    logic [THREAD_W-1:0] superscalar_thread;
    logic [3:0] src_reg;
    logic [3:0] dst_reg;
  } math_instr;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant of the first eligible requester at or after ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant
);
  logic [W-1:0] idx;
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr + W'(i);
      if (eligible[idx]) grant = N'(1) << idx;
    end
  end
endmodule

// File: rtl/math_issue_scheduler.sv
// math_issue_scheduler: round-robin issue of one math op per cycle with a per-thread busy scoreboard
// Optional MATH_SCHED_PERF_CNT_EN adds saturating perf_issued/perf_stall counters.
module math_issue_scheduler
  import cherry_defines::*;
#(
  parameter int NUM_THREADS = cherry_defines::NUM_THREADS,
  parameter int THREAD_W = cherry_defines::THREAD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   freeze,
  input  logic [NUM_THREADS-1:0] req_valid,
  output logic [NUM_THREADS-1:0] req_ready,
  output math_instr              issue_instr,
  input  logic                   wb_we,
  input  logic [THREAD_W+3:0]    wb_addr,
  output logic [NUM_THREADS-1:0] busy,
  output logic [NUM_THREADS-1:0] done
`ifdef MATH_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]            perf_issued,
  output logic [31:0]            perf_stall
`endif
);
  logic [THREAD_W-1:0] rr_ptr, gnt_id, wb_thread;
  logic [NUM_THREADS-1:0] eligible, clr;
  logic accept, unused_reg;
  math_instr nxt;
  assign eligible = req_valid & ~busy & {NUM_THREADS{~freeze & ~reset}};
  assign accept = |req_ready;
  assign wb_thread = wb_addr[THREAD_W+3:4];
  assign unused_reg = ^wb_addr[3:0];
  assign clr = wb_we ? NUM_THREADS'(1) << wb_thread : '0;
  rr_arbiter #(.N(NUM_THREADS), .W(THREAD_W)) u_arb (
    .eligible(eligible),
    .ptr(rr_ptr),
    .grant(req_ready)
  );
  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NUM_THREADS; i++) gnt_id = req_ready[i] ? THREAD_W'(i) : gnt_id;
    nxt = '0;
    nxt.valid = accept;
    nxt.superscalar_thread = gnt_id;
    nxt.src_reg = REG_MATMUL_OUTPUT;
    nxt.dst_reg = REG_MATMUL_INPUT;
  end
  // Frozen cycles hold everything: the pipeline consumes a held instr and writeback once.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      busy <= '0;
      done <= '0;
      issue_instr <= '0;
    end else if (!freeze) begin
      issue_instr <= nxt;
      busy <= (busy | req_ready) & ~clr;
      done <= clr;
      if (accept) rr_ptr <= gnt_id + 1'b1;
    end
  end
`ifdef MATH_SCHED_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued <= '0;
      perf_stall <= '0;
    end else begin
      if (accept && !(&perf_issued)) perf_issued <= perf_issued + 32'd1;
      if ((|(req_valid & busy) || (freeze && |req_valid)) && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
  a_no_set_clr: assert property (@(posedge clk) disable iff (reset) !(|(req_ready & clr)));
  a_wb_busy: assert property (@(posedge clk) disable iff (reset) (wb_we && !freeze) |-> |(busy & clr));
endmodule

// File: tb/tb_math_issue_scheduler.sv
// tb_math_issue_scheduler: randomized scoreboard bench with a 4-stage pipeline stand-in and a spec-level model
module tb_math_issue_scheduler;
  import cherry_defines::*;
  localparam int N = NUM_THREADS;
  typedef struct packed {
    logic v;
    logic [THREAD_W-1:0] t;
    logic [N-1:0] d;
  } exp_t;
  logic clk = 0, reset = 1, freeze = 0, wb_we;
  logic [N-1:0] req_valid = '0, req_ready, busy, done;
  logic [THREAD_W+3:0] wb_addr;
  math_instr issue_instr;
  math_instr pipe [4];
  int checks = 0, errors = 0;
  exp_t q[$];
  exp_t e;
  bit armed = 0;
  bit m_busy [N];
  int m_ptr = 0;
`ifdef MATH_SCHED_PERF_CNT_EN
  logic [31:0] perf_issued, perf_stall;
  int m_iss = 0, m_stall = 0;
`endif

  always #5 clk = ~clk;

  math_issue_scheduler dut (
    .clk(clk),
    .reset(reset),
    .freeze(freeze),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .issue_instr(issue_instr),
    .wb_we(wb_we),
    .wb_addr(wb_addr),
    .busy(busy),
    .done(done)
`ifdef MATH_SCHED_PERF_CNT_EN
    ,
    .perf_issued(perf_issued),
    .perf_stall(perf_stall)
`endif
  );

  // Stand-in for the shared math pipeline: four stages, stalls with freeze, flushed by reset
  assign wb_we = pipe[3].valid;
  assign wb_addr = {pipe[3].superscalar_thread, pipe[3].dst_reg};
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) pipe[i] <= '0;
    end else if (!freeze) begin
      pipe[0] <= issue_instr;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int t;
      t = (m_ptr + k) % N;
      if (req_valid[t] && !m_busy[t] && !freeze && !reset) return t;
    end
    return -1;
  endfunction

  function automatic int mvec();
    int v;
    v = 0;
    for (int k = 0; k < N; k++) if (m_busy[k]) v |= 1 << k;
    return v;
  endfunction

  // Reference model: checks combinational grant and busy, predicts the registered outputs of the next edge
  always @(negedge clk) begin : model
    int g, wt;
    g = pick();
    if (armed) begin
      check("req_ready", int'(req_ready), g < 0 ? 0 : 1 << g);
      check("busy", int'(busy), mvec());
`ifdef MATH_SCHED_PERF_CNT_EN
      check("perf_issued", int'(perf_issued), m_iss);
      check("perf_stall", int'(perf_stall), m_stall);
`endif
    end
`ifdef MATH_SCHED_PERF_CNT_EN
    if (reset) begin
      m_iss = 0;
      m_stall = 0;
    end else begin
      if (g >= 0) m_iss++;
      if ((int'(req_valid) & mvec()) != 0 || (freeze && req_valid != 0)) m_stall++;
    end
`endif
    if (reset) begin
      for (int k = 0; k < N; k++) m_busy[k] = 0;
      m_ptr = 0;
      e = '0;
      armed = 1;
    end else if (!freeze) begin
      e.d = '0;
      if (wb_we) begin
        wt = int'(wb_addr[THREAD_W+3:4]);
        e.d = N'(1) << wt;
        m_busy[wt] = 0;
      end
      e.v = g >= 0;
      e.t = g < 0 ? '0 : THREAD_W'(g);
      if (g >= 0) begin
        m_busy[g] = 1;
        m_ptr = (g + 1) % N;
      end
    end
    if (armed) q.push_back(e);
  end

  always begin : monitor
    exp_t x;
    @(posedge clk);
    #2;
    if (q.size() == 0) begin
      if (armed) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: no expected entry at %0t", $time);
      end
    end else begin
      x = q.pop_front();
      check("issue_valid", int'(issue_instr.valid), int'(x.v));
      if (x.v) check("issue_thread", int'(issue_instr.superscalar_thread), int'(x.t));
      check("done", int'(done), int'(x.d));
    end
  end

  initial begin
    int phase;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      phase = c / 500;
      reset = $urandom_range(0, 199) == 0;
      freeze = $urandom_range(0, 99) < ((phase % 2 == 1) ? 30 : 5);
      req_valid = (phase == 2 || phase == 5) ? '1 : N'($urandom);
    end
    reset = 0;
    freeze = 0;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
